// File: rtl/forward_pass_if.sv
// Request/response bundle between a host and the forward_pass engine.
// The host drives start and the weight/input snapshot; the engine returns status and results.
interface forward_pass_if #(
   parameter int DW = 16
);
   logic                    start;
   logic [1:0][DW-1:0]      x;
   logic [7:0][1:0][DW-1:0] currW0;
   logic [7:0][DW-1:0]      currb0;
   logic [2:0][7:0][DW-1:0] currW1;
   logic [2:0][DW-1:0]      currb1;
   logic                    busy;
   logic                    done;
   logic [7:0][DW-1:0]      hiddenlayerout;
   logic [2:0][DW-1:0]      logits;
   logic [1:0]              predictedstate;

   modport master (
      output start, x, currW0, currb0, currW1, currb1,
      input  busy, done, hiddenlayerout, logits, predictedstate
   );
   modport slave (
      input  start, x, currW0, currb0, currW1, currb1,
      output busy, done, hiddenlayerout, logits, predictedstate
   );
endinterface

// File: rtl/forward_pass.sv
// Sequential 2-8-3 MLP inference: one shared signed MAC, one product per cycle,
// hidden = ReLU(W0*x+b0), logits = W1*hidden+b1, predictedstate = argmax(logits).
module forward_pass #(
   parameter int DATAWIDTH = 16,
   parameter int FRAC      = 10,
   parameter int ACCW      = DATAWIDTH + 8
) (
   input  logic          clk,
   input  logic          rst,
   forward_pass_if.slave bus_io
);
   localparam int DW = DATAWIDTH;

   typedef enum logic [1:0] {IDLE, L0, L1, FIN} state_t;

   state_t                  state_q, state_d;
   logic [1:0][DW-1:0]      x_q, x_d;
   logic [7:0][1:0][DW-1:0] w0_q, w0_d;
   logic [7:0][DW-1:0]      b0_q, b0_d;
   logic [2:0][7:0][DW-1:0] w1_q, w1_d;
   logic [2:0][DW-1:0]      b1_q, b1_d;
   logic signed [ACCW-1:0]  acc_q, acc_d;
   logic [2:0]              n_q, n_d, k_q, k_d;
   logic [7:0][DW-1:0]      hid_q, hid_d;
   logic [2:0][DW-1:0]      lg_q, lg_d;
   logic [1:0]              pred_q, pred_d;
   logic                    done_q, done_d;

   logic signed [DW-1:0]    a, b, bias, sat, res, best;
   logic                    last;
   logic signed [2*DW-1:0]  prod, prod_sh;
   logic signed [ACCW-1:0]  p, r;
   logic [1:0]              amax;

   // Operand routing: layer 1 reads the hidden values produced earlier in this run
   always_comb begin
      a    = '0;
      b    = '0;
      bias = '0;
      last = 1'b0;
      if (state_q == L1) begin
         a    = hid_q[k_q];
         b    = w1_q[n_q[1:0]][k_q];
         bias = b1_q[n_q[1:0]];
         last = (k_q == 3'd7);
      end else begin
         a    = x_q[k_q[0]];
         b    = w0_q[n_q][k_q[0]];
         bias = b0_q[n_q];
         last = k_q[0];
      end
   end

   assign prod    = a * b;
   assign prod_sh = prod >>> FRAC;
   assign p       = prod_sh[ACCW-1:0];
   assign r       = acc_q + p + ACCW'(bias);

   // Clamp to the DW range when any bit above the DW sign bit disagrees with the sign
   always_comb begin
      sat = r[DW-1:0];
      if (r[ACCW-1:DW-1] != {(ACCW-DW+1){r[ACCW-1]}})
         sat = r[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      res = (state_q == L0 && sat[DW-1]) ? '0 : sat;
   end

   // Strict greater-than keeps the lowest index on ties
   always_comb begin
      amax = 2'd0;
      best = $signed(lg_q[0]);
      if ($signed(lg_q[1]) > best) begin
         amax = 2'd1;
         best = $signed(lg_q[1]);
      end
      if ($signed(lg_q[2]) > best) amax = 2'd2;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      w0_d    = w0_q;
      b0_d    = b0_q;
      w1_d    = w1_q;
      b1_d    = b1_q;
      acc_d   = acc_q;
      n_d     = n_q;
      k_d     = k_q;
      hid_d   = hid_q;
      lg_d    = lg_q;
      pred_d  = pred_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus_io.start) begin
            x_d     = bus_io.x;
            w0_d    = bus_io.currW0;
            b0_d    = bus_io.currb0;
            w1_d    = bus_io.currW1;
            b1_d    = bus_io.currb1;
            acc_d   = '0;
            n_d     = '0;
            k_d     = '0;
            state_d = L0;
         end
         L0: if (last) begin
            hid_d[n_q] = res;
            acc_d      = '0;
            k_d        = '0;
            if (n_q == 3'd7) begin
               n_d     = '0;
               state_d = L1;
            end else begin
               n_d = n_q + 3'd1;
            end
         end else begin
            acc_d = acc_q + p;
            k_d   = k_q + 3'd1;
         end
         L1: if (last) begin
            lg_d[n_q[1:0]] = res;
            acc_d          = '0;
            k_d            = '0;
            if (n_q == 3'd2) begin
               n_d     = '0;
               state_d = FIN;
            end else begin
               n_d = n_q + 3'd1;
            end
         end else begin
            acc_d = acc_q + p;
            k_d   = k_q + 3'd1;
         end
         FIN: begin
            done_d  = 1'b1;
            pred_d  = amax;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         w0_q    <= '0;
         b0_q    <= '0;
         w1_q    <= '0;
         b1_q    <= '0;
         acc_q   <= '0;
         n_q     <= '0;
         k_q     <= '0;
         hid_q   <= '0;
         lg_q    <= '0;
         pred_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         w0_q    <= w0_d;
         b0_q    <= b0_d;
         w1_q    <= w1_d;
         b1_q    <= b1_d;
         acc_q   <= acc_d;
         n_q     <= n_d;
         k_q     <= k_d;
         hid_q   <= hid_d;
         lg_q    <= lg_d;
         pred_q  <= pred_d;
         done_q  <= done_d;
      end
   end

   assign bus_io.busy           = (state_q == L0) || (state_q == L1);
   assign bus_io.done           = done_q;
   assign bus_io.hiddenlayerout = hid_q;
   assign bus_io.logits         = lg_q;
   assign bus_io.predictedstate = pred_q;
endmodule

// File: tb/tb_forward_pass.sv
// Scoreboard bench for forward_pass: expected results from a plain-arithmetic MLP model
// are queued at each start; a monitor pops and compares on every done pulse.
module tb_forward_pass;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   forward_pass_if #(.DW(16)) bus ();
   forward_pass #(.DATAWIDTH(16), .FRAC(10), .ACCW(24)) dut (.clk(clk), .rst(rst), .bus_io(bus));

   typedef struct packed {
      logic [7:0][15:0] hid;
      logic [2:0][15:0] lg;
      logic [1:0]       pred;
      logic [31:0]      due;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   int          bcnt  = 0;
   int unsigned cyc   = 0;

   int xs[2];
   int w0[8][2];
   int b0[8];
   int w1[3][8];
   int b1[3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic int sat16(longint s);
      if (s > 32767)  return 32767;
      if (s < -32768) return -32768;
      return int'(s);
   endfunction

   function automatic exp_t model();
      exp_t   e;
      longint s;
      int     h[8];
      int     l[3];
      int     bi;
      e = '0;
      for (int n = 0; n < 8; n++) begin
         s = b0[n];
         for (int k = 0; k < 2; k++) s += (longint'(xs[k]) * longint'(w0[n][k])) >>> 10;
         h[n] = sat16(s);
         if (h[n] < 0) h[n] = 0;
         e.hid[n] = h[n][15:0];
      end
      for (int m = 0; m < 3; m++) begin
         s = b1[m];
         for (int j = 0; j < 8; j++) s += (longint'(h[j]) * longint'(w1[m][j])) >>> 10;
         l[m] = sat16(s);
         e.lg[m] = l[m][15:0];
      end
      bi = 0;
      for (int i = 1; i < 3; i++) if (l[i] > l[bi]) bi = i;
      e.pred = bi[1:0];
      return e;
   endfunction

   function automatic int rfull();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   function automatic int rhalf();
      return int'($urandom_range(0, 32768)) - 16384;
   endfunction

   task automatic rnd();
      for (int k = 0; k < 2; k++) xs[k] = rfull();
      for (int n = 0; n < 8; n++) begin
         b0[n] = rfull();
         for (int k = 0; k < 2; k++) w0[n][k] = rfull();
      end
      for (int m = 0; m < 3; m++) begin
         b1[m] = rfull();
         for (int j = 0; j < 8; j++) w1[m][j] = rhalf();
      end
   endtask

   task automatic apply();
      for (int k = 0; k < 2; k++) bus.x[k] = xs[k][15:0];
      for (int n = 0; n < 8; n++) begin
         bus.currb0[n] = b0[n][15:0];
         for (int k = 0; k < 2; k++) bus.currW0[n][k] = w0[n][k][15:0];
      end
      for (int m = 0; m < 3; m++) begin
         bus.currb1[m] = b1[m][15:0];
         for (int j = 0; j < 8; j++) bus.currW1[m][j] = w1[m][j][15:0];
      end
   endtask

   task automatic launch(output exp_t e);
      @(negedge clk);
      apply();
      e = model();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      e.due = cyc + 41;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending results want 0", q.size());
         q.delete();
      end
   endtask

   task automatic run_one();
      exp_t e;
      launch(e);
      q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      drain();
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_hidden"}, bus.hiddenlayerout, '0);
      chk({tag, "_logits"}, bus.logits, '0);
      chk({tag, "_pred"}, bus.predictedstate, '0);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
   endtask

   initial begin
      exp_t e;
      bus.start = 1'b0;
      rnd();
      apply();

      fork
         forever begin
            @(negedge clk);
            if (rst) begin
               bcnt = 0;
            end else if (bus.done === 1'b1) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
               end else begin
                  mon_e = q.pop_front();
                  chk("hidden", bus.hiddenlayerout, mon_e.hid);
                  chk("logits", bus.logits, mon_e.lg);
                  chk("pred", bus.predictedstate, mon_e.pred);
                  chk("latency", cyc, mon_e.due);
                  chk("busy_cycles", bcnt, 40);
               end
               bcnt = 0;
            end else if (bus.busy === 1'b1) begin
               bcnt++;
            end
         end
      join_none

      // reset values, then start while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk("start_in_reset_busy", bus.busy, 1'b0);
      repeat (50) @(posedge clk);

      // basic run
      xs = '{1024, 2048};
      for (int n = 0; n < 8; n++) begin
         w0[n] = '{1024, 0};
         b0[n] = 0;
      end
      for (int j = 0; j < 8; j++) begin
         w1[0][j] = 128;
         w1[1][j] = 0;
         w1[2][j] = -128;
      end
      b1 = '{0, 512, 0};
      run_one();
      chk("basic_logit2", bus.logits[2], 16'hfc00);

      // ReLU and saturation
      rnd();
      xs = '{16384, 16384};
      w0[0] = '{-1024, 0};
      b0[0] = 0;
      w0[1] = '{32767, 32767};
      b0[1] = 32767;
      run_one();
      chk("relu_h0", bus.hiddenlayerout[0], 16'h0000);
      chk("sat_h1", bus.hiddenlayerout[1], 16'h7fff);

      // argmax tie
      rnd();
      for (int m = 0; m < 3; m++) for (int j = 0; j < 8; j++) w1[m][j] = 0;
      b1 = '{100, 300, 300};
      run_one();
      chk("tie_pred", bus.predictedstate, 2'd1);

      // start pulse and input change mid-run, then a second run on the new inputs
      rnd();
      launch(e);
      q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.start = 1'b1;
      xs[0] = rfull();
      xs[1] = rfull();
      w0[3][1] = rfull();
      apply();
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      run_one();

      // start held high re-triggers right after done
      rnd();
      launch(e);
      q.push_back(e);
      e.due = e.due + 42;
      q.push_back(e);
      while (cyc < e.due - 41) @(negedge clk);
      bus.start = 1'b0;
      drain();

      // reset mid-run aborts without done
      rnd();
      launch(e);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (18) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("midrun_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(posedge clk);
      rnd();
      run_one();

      // random runs
      repeat (8) begin
         rnd();
         run_one();
      end

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
